regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle MUL/DIV unit. It buffers MUL/DIV results in a 2-entry FIFO and emits one registered write per cycle to the register file. It also keeps a per-register pending scoreboard for outstanding MUL/DIV destinations, so decode can stall on RAW/WAW hazards. It sits between the writeback stage, the MUL/DIV unit, and the register file's IN/INADDRESS/WRITE inputs.

## Interface
- DEPTH, 2, MUL/DIV result FIFO entries (fixed at 2; the pointer width is 1 bit).
- CLK  in  1  single clock; all state updates on the posedge.
- RESET  in  1  synchronous, active-low reset, sampled on the CLK posedge.
- WB_WRITE  in  1  pipeline writeback request; cannot be stalled.
- WB_ADDR  in  5  pipeline destination register.
- WB_DATA  in  32  pipeline result.
- MD_VALID  in  1  MUL/DIV result valid.
- MD_READY  out  1  arbiter can accept a MUL/DIV result.
- MD_ADDR  in  5  MUL/DIV destination register.
- MD_DATA  in  32  MUL/DIV result.
- MD_ISSUE  in  1  decode issues a MUL/DIV op this cycle.
- MD_ISSUE_ADDR  in  5  rd of the issued MUL/DIV op.
- RS1, RS2, RD  in  5 each  register addresses of the instruction in decode.
- STALL  out  1  combinational hazard indication to decode.
- RF_WRITE  out  1  registered write enable to the register file.
- RF_INADDRESS  out  5  registered write address.
- RF_IN  out  32  registered write data.
- PENDING  out  32  scoreboard bit vector; bit 0 is always 0.
- ERR  out  1  sticky protocol-violation flag.

## Operation
- Handshake: a MUL/DIV result is accepted when MD_VALID & MD_READY are high at a posedge. MD_VALID, MD_ADDR and MD_DATA hold until acceptance.
- MD_READY = RESET & (fifo count < 2). It is derived from registered state only.
- Write-port priority per cycle, highest first:
  1. WB_WRITE: RF_* <= WB_*.
  2. FIFO non-empty: pop the head into RF_*.
  3. FIFO empty and an MD result accepted this cycle: bypass it straight to RF_*. It is not enqueued.
  4. Otherwise RF_WRITE <= 0. RF_INADDRESS and RF_IN hold their previous values.
- An accepted MD result that is not bypassed is enqueued at the tail. Push and pop in the same cycle are legal; the count is unchanged.
- FIFO order is strict: MD results reach the register file in acceptance order.
- x0: any selected write with address 0 drives RF_WRITE <= 0, but RF_INADDRESS and RF_IN still update. A popped or bypassed x0 entry is consumed normally.
- Scoreboard:
  - MD_ISSUE with MD_ISSUE_ADDR != 0 sets PENDING[MD_ISSUE_ADDR].
  - Emitting an MD-sourced write to address a clears PENDING[a].
  - If a set and a clear hit the same address in one cycle, the set wins.
- STALL = PENDING[RS1] | PENDING[RS2] | PENDING[RD]. It is purely combinational.
- ERR is set, and held until reset, on any of:
  - WB_WRITE to an address whose PENDING bit is 1.
  - MD_ISSUE to an already-pending address.
  - An MD result emitted for a non-pending address other than x0.
- WB_WRITE to a pending register does not clear the pending bit.

## Timing
- Reset (RESET low at a posedge) forces:
  - RF_WRITE=0, RF_INADDRESS=0, RF_IN=0.
  - FIFO empty; pointers at 0.
  - PENDING=0, ERR=0.
  - MD_READY=0 while RESET is low.
- Reset mid-operation discards FIFO contents and the scoreboard; no write is emitted in the reset cycle.
- Latency:
  - WB request → RF_WRITE high after 1 posedge.
  - MD accept with the FIFO empty and WB idle → RF_WRITE high after 1 posedge.
  - Each cycle of WB activity delays queued MD results by 1 cycle.
- MD_READY falls in the cycle after the FIFO reaches 2 entries. It rises in the cycle after the first pop.
- Sustained WB_WRITE starves the MD path; the FIFO fills and MD_READY stays 0. This is intended, because the pipeline cannot stall at writeback.
- The register file samples RF_* on the next posedge, so an MD result is architecturally visible 2 posedges after acceptance. PENDING clears at the same posedge that RF_WRITE is driven high.

## Test plan
- Reset: hold RESET=0 for 2 cycles with MD_VALID=1 and WB_WRITE=1 → all outputs 0, MD_READY=0, and no RF_WRITE afterwards until a new request.
- Bypass: idle WB, MD_VALID with MD_ADDR=5, MD_DATA=0x1234 → next cycle RF_WRITE=1, RF_INADDRESS=5, RF_IN=0x1234. PENDING[5] (set by an earlier issue) clears at the same edge.
- Contention: WB_WRITE held 4 cycles (addr 3) while MD offers results A (x6), B (x7), C (x8) → A and B queue, MD_READY=0 blocks C. After WB drops, writes emerge as x6, x7, then x8 on consecutive cycles.
- Scoreboard stall: MD_ISSUE to x10, then decode with RS2=10 → STALL=1 until the cycle the x10 MD write is emitted. STALL=0 the cycle after.
- x0 and ERR:
  - MD result to x0 → RF_WRITE stays 0 and the FIFO entry is consumed.
  - WB_WRITE to pending x12 → ERR=1, and it stays 1 until reset.
- Set/clear collision: MD write to x9 emitted in the same cycle as MD_ISSUE to x9 → PENDING[9]=1 afterwards.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter_if
//  Purpose  : Bundles the writeback, MUL/DIV, decode-hazard and register-file
//             write signals seen by regfile_write_arbiter.
//  Ports    : none (signal container). Modports:
//               slave  - the arbiter: consumes requests, drives RF_*/status
//               master - the surrounding pipeline / testbench
//  Signals  : wb_write/wb_addr/wb_data        writeback request
//             md_valid/md_ready/md_addr/md_data MUL/DIV result handshake
//             md_issue/md_issue_addr           MUL/DIV issue from decode
//             rs1/rs2/rd, stall                decode hazard query
//             rf_write/rf_inaddress/rf_in      register-file write port
//             pending, err                     scoreboard and protocol flag
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;

   logic        wb_write;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_addr;
   logic [31:0] md_data;

   logic        md_issue;
   logic [4:0]  md_issue_addr;

   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        stall;

   logic        rf_write;
   logic [4:0]  rf_inaddress;
   logic [31:0] rf_in;

   logic [31:0] pending;
   logic        err;

   modport slave (
      input  wb_write, wb_addr, wb_data,
      input  md_valid, md_addr, md_data,
      input  md_issue, md_issue_addr,
      input  rs1, rs2, rd,
      output md_ready, stall,
      output rf_write, rf_inaddress, rf_in,
      output pending, err
   );

   modport master (
      output wb_write, wb_addr, wb_data,
      output md_valid, md_addr, md_data,
      output md_issue, md_issue_addr,
      output rs1, rs2, rd,
      input  md_ready, stall,
      input  rf_write, rf_inaddress, rf_in,
      input  pending, err
   );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Shares the single register-file write port between the
//             pipeline writeback stage and the MUL/DIV unit. MUL/DIV results
//             are buffered in a 2-entry FIFO; one registered write per cycle
//             is emitted. A per-register pending scoreboard tracks issued
//             MUL/DIV destinations so decode can stall on RAW/WAW hazards.
//  Ports    : clk_i   - clock, all state updates on the rising edge
//             rst_ni  - synchronous active-low reset
//             bus     - regfile_write_arbiter_if.slave (requests, RF write
//                       port, scoreboard, stall and error outputs)
//  Params   : DEPTH   - MUL/DIV FIFO entries, fixed at 2 (1-bit pointers)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   regfile_write_arbiter_if.slave       bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Write-port source select, highest priority first.
   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_WB   = 2'd1;
   localparam logic [1:0] SEL_POP  = 2'd2;
   localparam logic [1:0] SEL_BYP  = 2'd3;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4:0]       fifo_addr_q [DEPTH];
   logic [31:0]      fifo_data_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic             rf_write_q,     rf_write_d;
   logic [4:0]       rf_inaddress_q, rf_inaddress_d;
   logic [31:0]      rf_in_q,        rf_in_d;

   logic [31:0]      pending_q, pending_d;
   logic             err_q,     err_d;

   // ------------------------------------------------------------------------
   // Handshake and source selection
   // ------------------------------------------------------------------------
   logic        md_ready;
   logic        md_accept;
   logic        fifo_empty;
   logic [1:0]  sel;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;
   logic        md_emit;
   logic        push;
   logic        pop;

   // Ready depends only on the registered count, never on this cycle's pop,
   // so it cannot form a combinational loop with the MUL/DIV unit.
   assign md_ready   = rst_ni & (count_q < DEPTH_C);
   assign md_accept  = bus.md_valid & md_ready;
   assign fifo_empty = (count_q == '0);

   always_comb begin
      sel = SEL_NONE;
      if (bus.wb_write) begin
         sel = SEL_WB;
      end else if (!fifo_empty) begin
         sel = SEL_POP;
      end else if (md_accept) begin
         sel = SEL_BYP;
      end
   end

   always_comb begin
      sel_addr = rf_inaddress_q;
      sel_data = rf_in_q;
      unique case (sel)
         SEL_WB: begin
            sel_addr = bus.wb_addr;
            sel_data = bus.wb_data;
         end
         SEL_POP: begin
            sel_addr = fifo_addr_q[rd_ptr_q];
            sel_data = fifo_data_q[rd_ptr_q];
         end
         SEL_BYP: begin
            sel_addr = bus.md_addr;
            sel_data = bus.md_data;
         end
         default: begin
            sel_addr = rf_inaddress_q;
            sel_data = rf_in_q;
         end
      endcase
   end

   assign md_emit = (sel == SEL_POP) | (sel == SEL_BYP);
   assign pop     = (sel == SEL_POP);
   // A bypassed result goes straight to the port and never occupies a slot.
   assign push    = md_accept & (sel != SEL_BYP);

   // ------------------------------------------------------------------------
   // FIFO bookkeeping (DEPTH is a power of two, so pointers wrap naturally)
   // ------------------------------------------------------------------------
   always_comb begin
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Register-file write port
   // ------------------------------------------------------------------------
   always_comb begin
      // x0 writes still move address/data but never assert the enable.
      rf_write_d     = (sel != SEL_NONE) & (sel_addr != 5'd0);
      rf_inaddress_d = sel_addr;
      rf_in_d        = sel_data;
   end

   // ------------------------------------------------------------------------
   // Pending scoreboard: set by issue, cleared by an emitted MD write; a
   // set and clear to the same register in one cycle leaves it set.
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < 32; gi++) begin : g_pending
      if (gi == 0) begin : g_zero
         assign pending_d[gi] = 1'b0;
      end else begin : g_bit
         logic set_hit;
         logic clr_hit;
         assign set_hit = bus.md_issue & (bus.md_issue_addr == 5'(gi));
         assign clr_hit = md_emit & (sel_addr == 5'(gi));
         assign pending_d[gi] = set_hit | (pending_q[gi] & ~clr_hit);
      end
   end

   // ------------------------------------------------------------------------
   // Protocol-violation detection (sticky)
   // ------------------------------------------------------------------------
   logic err_wb;
   logic err_issue;
   logic err_md;

   assign err_wb    = bus.wb_write & pending_q[bus.wb_addr];
   assign err_issue = bus.md_issue & pending_q[bus.md_issue_addr];
   assign err_md    = md_emit & (sel_addr != 5'd0) & ~pending_q[sel_addr];
   assign err_d     = err_q | err_wb | err_issue | err_md;

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         rf_write_q     <= 1'b0;
         rf_inaddress_q <= '0;
         rf_in_q        <= '0;
         pending_q      <= '0;
         err_q          <= 1'b0;
      end else begin
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         rf_write_q     <= rf_write_d;
         rf_inaddress_q <= rf_inaddress_d;
         rf_in_q        <= rf_in_d;
         pending_q      <= pending_d;
         err_q          <= err_d;
      end
   end

   // Storage needs no reset: occupancy is governed by count/pointers.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= bus.md_addr;
         fifo_data_q[wr_ptr_q] <= bus.md_data;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.md_ready     = md_ready;
   assign bus.stall        = pending_q[bus.rs1] | pending_q[bus.rs2] | pending_q[bus.rd];
   assign bus.rf_write     = rf_write_q;
   assign bus.rf_inaddress = rf_inaddress_q;
   assign bus.rf_in        = rf_in_q;
   assign bus.pending      = pending_q;
   assign bus.err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_arbiter
//  Purpose  : Self-checking bench for regfile_write_arbiter. A cycle model
//             predicts each registered write, the scoreboard vector and the
//             error flag; predictions are queued when stimulus is driven and
//             compared after the clock edge that produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } md_item_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pend;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   regfile_write_arbiter_if bus ();

   regfile_write_arbiter #(.DEPTH(2)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   md_item_t src_q[$];   // MD results waiting to be offered
   md_item_t m_fifo[$];  // model of the arbiter FIFO
   exp_t     exp_q[$];   // scoreboard of predicted outputs

   logic [31:0] m_pend = '0;
   logic        m_err  = 1'b0;
   logic        m_we   = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_md(input logic [4:0] a, input logic [31:0] d);
      md_item_t it;
      it.addr = a;
      it.data = d;
      src_q.push_back(it);
   endtask

   // One clock: present inputs, check combinational outputs, predict, clock,
   // then compare the registered outputs against the prediction.
   task automatic step();
      md_item_t    hd;
      md_item_t    it;
      exp_t        e;
      exp_t        got;
      logic        ready, acc, emit_md, byp, we_sel, werr, exp_stall;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] np;

      if (src_q.size() > 0) begin
         bus.md_valid = 1'b1;
         bus.md_addr  = src_q[0].addr;
         bus.md_data  = src_q[0].data;
      end else begin
         bus.md_valid = 1'b0;
      end
      #1;

      ready     = rst_n && (m_fifo.size() < 2);
      exp_stall = m_pend[bus.rs1] | m_pend[bus.rs2] | m_pend[bus.rd];
      check("md_ready", 64'(bus.md_ready), 64'(ready));
      check("stall", 64'(bus.stall), 64'(exp_stall));
      acc = bus.md_valid && ready;

      if (!rst_n) begin
         m_fifo.delete();
         m_pend = '0;
         m_err  = 1'b0;
         m_we   = 1'b0;
         m_addr = '0;
         m_data = '0;
      end else begin
         emit_md = 1'b0;
         byp     = 1'b0;
         we_sel  = 1'b0;
         werr    = m_err;
         a       = m_addr;
         d       = m_data;
         if (bus.wb_write) begin
            we_sel = 1'b1;
            a      = bus.wb_addr;
            d      = bus.wb_data;
            if (m_pend[a]) werr = 1'b1;
         end else if (m_fifo.size() > 0) begin
            hd      = m_fifo.pop_front();
            we_sel  = 1'b1;
            a       = hd.addr;
            d       = hd.data;
            emit_md = 1'b1;
         end else if (acc) begin
            we_sel  = 1'b1;
            a       = bus.md_addr;
            d       = bus.md_data;
            emit_md = 1'b1;
            byp     = 1'b1;
         end
         if (acc && !byp) begin
            it.addr = bus.md_addr;
            it.data = bus.md_data;
            m_fifo.push_back(it);
         end
         if (bus.md_issue && m_pend[bus.md_issue_addr]) werr = 1'b1;
         if (emit_md && a != 5'd0 && !m_pend[a]) werr = 1'b1;
         np = m_pend;
         if (emit_md) np[a] = 1'b0;
         if (bus.md_issue && bus.md_issue_addr != 5'd0) np[bus.md_issue_addr] = 1'b1;
         np[0]  = 1'b0;
         m_pend = np;
         m_err  = werr;
         m_we   = we_sel && (a != 5'd0);
         if (we_sel) begin
            m_addr = a;
            m_data = d;
         end
      end

      e.we   = m_we;
      e.addr = m_addr;
      e.data = m_data;
      e.pend = m_pend;
      e.err  = m_err;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      if (acc) void'(src_q.pop_front());

      e = exp_q.pop_front();
      got.we   = bus.rf_write;
      got.addr = bus.rf_inaddress;
      got.data = bus.rf_in;
      got.pend = bus.pending;
      got.err  = bus.err;
      check("rf_write", 64'(got.we), 64'(e.we));
      check("rf_inaddress", 64'(got.addr), 64'(e.addr));
      check("rf_in", 64'(got.data), 64'(e.data));
      check("pending", 64'(got.pend), 64'(e.pend));
      check("err", 64'(got.err), 64'(e.err));
   endtask

   task automatic issue(input logic [4:0] a);
      bus.md_issue      = 1'b1;
      bus.md_issue_addr = a;
      step();
      bus.md_issue      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      bus.wb_write      = 1'b0;
      bus.wb_addr       = '0;
      bus.wb_data       = '0;
      bus.md_valid      = 1'b0;
      bus.md_addr       = '0;
      bus.md_data       = '0;
      bus.md_issue      = 1'b0;
      bus.md_issue_addr = '0;
      bus.rs1           = '0;
      bus.rs2           = '0;
      bus.rd            = '0;
      @(posedge clk);
      #1;

      // Reset held two cycles with both requesters active.
      bus.wb_write = 1'b1;
      bus.wb_addr  = 5'd4;
      bus.wb_data  = 32'hAAAA_AAAA;
      push_md(5'd4, 32'h5555_5555);
      step();
      step();
      check("rst_rf_write", 64'(bus.rf_write), 64'd0);
      check("rst_rf_addr", 64'(bus.rf_inaddress), 64'd0);
      check("rst_rf_in", 64'(bus.rf_in), 64'd0);
      check("rst_pending", 64'(bus.pending), 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
      check("rst_md_ready", 64'(bus.md_ready), 64'd0);
      rst_n        = 1'b1;
      bus.wb_write = 1'b0;
      src_q.delete();
      step();
      check("post_rst_idle", 64'(bus.rf_write), 64'd0);

      // Bypass with empty FIFO and idle writeback.
      issue(5'd5);
      check("issue_sets_p5", 64'(bus.pending[5]), 64'd1);
      push_md(5'd5, 32'h0000_1234);
      step();
      check("byp_we", 64'(bus.rf_write), 64'd1);
      check("byp_addr", 64'(bus.rf_inaddress), 64'd5);
      check("byp_data", 64'(bus.rf_in), 64'h1234);
      check("byp_clr_p5", 64'(bus.pending[5]), 64'd0);

      // Contention: writeback holds the port for four cycles.
      issue(5'd6);
      issue(5'd7);
      issue(5'd8);
      bus.wb_write = 1'b1;
      bus.wb_addr  = 5'd3;
      bus.wb_data  = 32'h3333_3333;
      push_md(5'd6, 32'h6666_0006);
      push_md(5'd7, 32'h7777_0007);
      push_md(5'd8, 32'h8888_0008);
      repeat (4) step();
      check("cont_ready_low", 64'(bus.md_ready), 64'd0);
      check("cont_c_blocked", 64'(src_q.size()), 64'd1);
      bus.wb_write = 1'b0;
      step();
      check("cont_first_x6", 64'(bus.rf_inaddress), 64'd6);
      step();
      check("cont_second_x7", 64'(bus.rf_inaddress), 64'd7);
      step();
      check("cont_third_x8", 64'(bus.rf_inaddress), 64'd8);
      check("cont_third_data", 64'(bus.rf_in), 64'h8888_0008);

      // Scoreboard stall on RS2.
      issue(5'd10);
      bus.rs2 = 5'd10;
      step();
      check("stall_held", 64'(bus.stall), 64'd1);
      push_md(5'd10, 32'hA0A0_A0A0);
      step();
      check("stall_clear_addr", 64'(bus.rf_inaddress), 64'd10);
      check("stall_cleared", 64'(bus.stall), 64'd0);
      bus.rs2 = 5'd0;

      // x0 results: bypassed and queued.
      push_md(5'd0, 32'hDEAD_0000);
      step();
      check("x0_we", 64'(bus.rf_write), 64'd0);
      check("x0_data", 64'(bus.rf_in), 64'hDEAD_0000);
      bus.wb_write = 1'b1;
      bus.wb_addr  = 5'd1;
      bus.wb_data  = 32'h0000_0001;
      push_md(5'd0, 32'hBEEF_0000);
      step();
      bus.wb_write = 1'b0;
      step();
      check("x0q_we", 64'(bus.rf_write), 64'd0);
      check("x0q_data", 64'(bus.rf_in), 64'hBEEF_0000);
      check("x0q_drained", 64'(bus.md_ready), 64'd1);
      check("err_clean", 64'(bus.err), 64'd0);

      // Writeback to a pending register flags a sticky error.
      issue(5'd12);
      bus.wb_write = 1'b1;
      bus.wb_addr  = 5'd12;
      bus.wb_data  = 32'h0000_000C;
      step();
      bus.wb_write = 1'b0;
      check("err_set", 64'(bus.err), 64'd1);
      check("wb_keeps_p12", 64'(bus.pending[12]), 64'd1);
      repeat (3) step();
      check("err_sticky", 64'(bus.err), 64'd1);

      // Set/clear collision on x9.
      issue(5'd9);
      bus.md_issue      = 1'b1;
      bus.md_issue_addr = 5'd9;
      push_md(5'd9, 32'h9999_0009);
      step();
      bus.md_issue = 1'b0;
      check("collide_we", 64'(bus.rf_write), 64'd1);
      check("collide_p9", 64'(bus.pending[9]), 64'd1);

      // Random traffic against the model.
      for (int i = 0; i < 80; i++) begin
         bus.wb_write      = ($urandom_range(0, 3) == 0);
         bus.wb_addr       = 5'($urandom_range(0, 31));
         bus.wb_data       = $urandom;
         bus.md_issue      = ($urandom_range(0, 4) == 0);
         bus.md_issue_addr = 5'($urandom_range(0, 31));
         bus.rs1           = 5'($urandom_range(0, 31));
         bus.rs2           = 5'($urandom_range(0, 31));
         bus.rd            = 5'($urandom_range(0, 31));
         if (src_q.size() < 2 && $urandom_range(0, 1) == 1)
            push_md(5'($urandom_range(0, 31)), $urandom);
         step();
      end

      // Reset in the middle of traffic with the FIFO loaded.
      bus.md_issue = 1'b0;
      bus.wb_write = 1'b1;
      bus.wb_addr  = 5'd2;
      bus.wb_data  = 32'h2222_2222;
      push_md(5'd13, 32'h1313_1313);
      push_md(5'd14, 32'h1414_1414);
      step();
      step();
      rst_n = 1'b0;
      step();
      check("midrst_we", 64'(bus.rf_write), 64'd0);
      check("midrst_pending", 64'(bus.pending), 64'd0);
      check("midrst_err", 64'(bus.err), 64'd0);
      rst_n        = 1'b1;
      bus.wb_write = 1'b0;
      src_q.delete();
      step();
      check("midrst_fifo_gone", 64'(bus.rf_write), 64'd0);
      check("midrst_ready", 64'(bus.md_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
